range_sampler: RTL and testbench
================================

# range_sampler

Consumer end of the random-number generator. It keeps the generator stirring with a roll enable and captures the generator's raw value when the game logic requests a random value. It reduces that value into the range MIN_VAL..MIN_VAL+SPAN-1, optionally rejecting an immediate repeat, and presents the result to the game logic (platform distance / placement) over a valid/ack handshake.

## Interface

Parameters:
- WIDTH, 7, width of the raw random value from the generator
- OUT_WIDTH, 7, width of o_value; must hold MIN_VAL+SPAN-1
- MIN_VAL, 10, smallest value delivered
- SPAN, 40, number of distinct values delivered; 1 <= SPAN <= 2^WIDTH
- NO_REPEAT, 1, 1 = reject an offset equal to the previous delivered offset
- MAX_RETRY, 3, maximum resamples per request before the repeat is accepted

Ports:
- clk_sampler  input  1  single clock, rising edge
- rst_sampler_n  input  1  reset, asynchronous, active-low
- o_roll  output  1  roll enable to the generator's i_roll
- i_random_binary  input  WIDTH  raw value from the generator
- i_req  input  1  request a new value; level, sampled only in IDLE
- o_busy  output  1  high in REDUCE and RESAMPLE
- o_valid  output  1  o_value holds a delivered value
- i_ack  input  1  consumer accepts o_value; meaningful only while o_valid=1
- o_value  output  OUT_WIDTH  delivered value, registered

## Operation

- All outputs and state are registered.
- **Reset values:** state=IDLE, o_roll=0, o_valid=0, o_busy=0, o_value=0, work=0, last_off=0, have_last=0, retry=0.
- **o_roll:** goes to 1 on the first edge after reset release and stays 1 in every state, so the generator always advances.
- **IDLE:**
  - On i_req=1: work<=i_random_binary, retry<=0, go to REDUCE.
  - Otherwise remain in IDLE.
- **REDUCE:** repeated subtraction implements modulo.
  - If work >= SPAN: work<=work-SPAN and stay in REDUCE.
  - Else, if NO_REPEAT=1, have_last=1, work==last_off and retry<MAX_RETRY: retry<=retry+1, go to RESAMPLE.
  - Else: o_value<=MIN_VAL+work, last_off<=work, have_last<=1, o_valid<=1, go to VALID.
- **RESAMPLE:** work<=i_random_binary, go to REDUCE.
- **VALID:**
  - o_valid=1 and o_value is stable.
  - i_req is ignored.
  - On i_ack=1: o_valid<=0, go to IDLE. o_value retains its last value.
- **Width rules:**
  - The subtract compare is performed at WIDTH+1 bits.
  - MIN_VAL+work is computed at OUT_WIDTH bits with no wrap, guaranteed by the parameter constraint.
  - retry is sized for MAX_RETRY.

## Timing

- Let k = floor(raw/SPAN), with raw captured at the edge that samples i_req in IDLE.
- **Latency:** o_valid is high after edge k+1 following that capture edge, when no resample occurs.
- **Each resample:** adds 1 edge (RESAMPLE) plus k' + 1 edges in REDUCE for the new raw value.
- **Worst case:** bounded by (MAX_RETRY+1)·(ceil(2^WIDTH/SPAN)+1) edges.
- **Handshake:**
  - o_valid falls on the edge that samples i_ack=1.
  - The earliest next capture is the edge after that, so back-to-back requests take ≥1 IDLE cycle.
  - i_ack while o_valid=0 has no effect.
- **Simultaneous events:**
  - i_req and i_ack both high in VALID: ack is honoured and req is ignored. It is re-sampled in IDLE if still held.
- **Reset mid-operation:** any state returns to IDLE immediately, have_last is cleared, and a pending request is lost.
- **SPAN = 2^WIDTH:** REDUCE always completes in one edge.

## Structure

- **Shared package:**
  - State typedef: IDLE, REDUCE, RESAMPLE, VALID, 2-bit encoding.
  - Default parameter constants: WIDTH, SPAN, MIN_VAL.
- **Sub-modules:** none. The generator is instantiated beside this block by the parent, wired o_roll→i_roll and o_random_binary→i_random_binary. The same clock is used and reset is inverted at the parent.
- **Size:** estimated 150–250 lines.

## Test plan

All scenarios use WIDTH=7, SPAN=40, MIN_VAL=10, and drive i_random_binary directly from the bench.

1. **Short reduction:** raw=5, i_req=1 → o_valid high after edge 1, o_value=15, o_busy high for 1 cycle.
2. **Maximum subtractions:** raw=127 → 3 subtractions, o_value=17 after edge 4. Hold i_ack=0 for 10 cycles → o_value stays 17 and o_valid stays 1.
3. **Repeat rejection:**
   - Deliver 17, then request with raw=47 (offset 7) → RESAMPLE entered.
   - Bench drives raw=8 in RESAMPLE → o_value=18.
   - With raw held at 47 on every sample, the result is accepted as 17 after 3 retries.
4. **Request ignored in VALID:** i_req=1 together with i_ack=1 in VALID → returns to IDLE with no new capture that edge. The next request is captured one edge later.
5. **Reset mid-operation:** assert rst_sampler_n=0 during REDUCE with raw=127 → all outputs take reset values asynchronously. After release, o_roll goes to 1 after one edge. The next request with offset 7 is not rejected, since have_last was cleared.

Source files
------------

// File: rtl/range_sampler_pkg.sv
// Shared definitions for the random-value consumer: FSM encoding, default
// parameter values and a sizing helper for the retry counter.
package range_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDUCE   = 2'd1,
    RESAMPLE = 2'd2,
    VALID    = 2'd3
  } state_e;

  localparam int DEF_WIDTH   = 7;
  localparam int DEF_SPAN    = 40;
  localparam int DEF_MIN_VAL = 10;

  // A zero-retry configuration still needs a one-bit counter to stay legal.
  function automatic int retry_bits(input int max_retry);
    return (max_retry > 0) ? $clog2(max_retry + 1) : 1;
  endfunction

endpackage

// File: rtl/range_sampler.sv
// Captures the generator's raw value on request, reduces it into
// MIN_VAL..MIN_VAL+SPAN-1 by repeated subtraction and delivers it over valid/ack.
module range_sampler
  import range_sampler_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = 7,
  parameter int MIN_VAL   = DEF_MIN_VAL,
  parameter int SPAN      = DEF_SPAN,
  parameter bit NO_REPEAT = 1'b1,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk_sampler,
  input  logic                 rst_sampler_n,
  output logic                 o_roll,
  input  logic [WIDTH-1:0]     i_random_binary,
  input  logic                 i_req,
  output logic                 o_busy,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [OUT_WIDTH-1:0] o_value
);

  localparam int RW = retry_bits(MAX_RETRY);

  // SPAN may equal 2^WIDTH, so the compare needs one extra bit.
  localparam logic [WIDTH:0]     SPAN_W      = (WIDTH + 1)'(SPAN);
  localparam logic [OUT_WIDTH-1:0] MIN_W     = OUT_WIDTH'(MIN_VAL);
  localparam logic [RW-1:0]      RETRY_MAX_W = RW'(MAX_RETRY);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic [WIDTH-1:0]       last_off_q, last_off_d;
  logic                   have_last_q, have_last_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   roll_q, roll_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [OUT_WIDTH-1:0]   value_q, value_d;

  logic [WIDTH:0]         work_ext;
  logic [WIDTH:0]         work_minus;
  logic                   reject;

  assign work_ext   = {1'b0, work_q};
  assign work_minus = work_ext - SPAN_W;
  assign reject     = NO_REPEAT && have_last_q && (work_q == last_off_q)
                      && (retry_q < RETRY_MAX_W);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    last_off_d  = last_off_q;
    have_last_d = have_last_q;
    retry_d     = retry_q;
    value_d     = value_q;
    roll_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          work_d  = i_random_binary;
          retry_d = '0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (work_ext >= SPAN_W) begin
          work_d = work_minus[WIDTH-1:0];
        end else if (reject) begin
          retry_d = retry_q + RW'(1);
          state_d = RESAMPLE;
        end else begin
          value_d     = MIN_W + OUT_WIDTH'(work_q);
          last_off_d  = work_q;
          have_last_d = 1'b1;
          state_d     = VALID;
        end
      end
      RESAMPLE: begin
        work_d  = i_random_binary;
        state_d = REDUCE;
      end
      VALID: begin
        // A request arriving with the ack is ignored; IDLE re-samples it.
        if (i_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d  = (state_d == REDUCE) || (state_d == RESAMPLE);
    valid_d = (state_d == VALID);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sampler or negedge rst_sampler_n) begin
    if (!rst_sampler_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      last_off_q  <= '0;
      have_last_q <= 1'b0;
      retry_q     <= '0;
      roll_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      last_off_q  <= last_off_d;
      have_last_q <= have_last_d;
      retry_q     <= retry_d;
      roll_q      <= roll_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
    end
  end

  assign o_roll  = roll_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_value = value_q;

endmodule

// File: tb/tb_range_sampler.sv
// Directed bench for range_sampler: a table of single-request vectors plus
// hand-written sequences for hold, repeat rejection, req/ack overlap and reset.
module tb_range_sampler;
  import range_sampler_pkg::*;

  localparam int BUDGET = 60;

  logic       clk_sampler = 1'b0;
  logic       rst_sampler_n = 1'b0;
  logic       o_roll;
  logic [6:0] i_random_binary = '0;
  logic       i_req = 1'b0;
  logic       o_busy;
  logic       o_valid;
  logic       i_ack = 1'b0;
  logic [6:0] o_value;

  range_sampler #(
    .WIDTH(7), .OUT_WIDTH(7), .MIN_VAL(10), .SPAN(40), .NO_REPEAT(1'b1), .MAX_RETRY(3)
  ) dut (
    .clk_sampler     (clk_sampler),
    .rst_sampler_n   (rst_sampler_n),
    .o_roll          (o_roll),
    .i_random_binary (i_random_binary),
    .i_req           (i_req),
    .o_busy          (o_busy),
    .o_valid         (o_valid),
    .i_ack           (i_ack),
    .o_value         (o_value)
  );

  always #5 clk_sampler = ~clk_sampler;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] raw;
    int         exp_lat;
    int         exp_val;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sampler);
    #1;
  endtask

  // Present raw with i_req for exactly the capture edge.
  task automatic request(input logic [6:0] raw);
    i_random_binary = raw;
    i_req = 1'b1;
    step();
    i_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < BUDGET) begin
      step();
      lat++;
    end
  endtask

  task automatic do_ack();
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
  endtask

  initial begin
    int lat;

    vecs[0] = '{raw: 7'd5,   exp_lat: 1, exp_val: 15};
    vecs[1] = '{raw: 7'd127, exp_lat: 4, exp_val: 17};
    vecs[2] = '{raw: 7'd40,  exp_lat: 2, exp_val: 10};
    vecs[3] = '{raw: 7'd39,  exp_lat: 1, exp_val: 49};
    vecs[4] = '{raw: 7'd80,  exp_lat: 3, exp_val: 10};
    vecs[5] = '{raw: 7'd126, exp_lat: 4, exp_val: 16};

    // Reset state and o_roll rising one edge after release.
    #1;
    check("rst_roll",  o_roll,  0);
    check("rst_valid", o_valid, 0);
    check("rst_busy",  o_busy,  0);
    check("rst_value", o_value, 0);
    #11 rst_sampler_n = 1'b1;
    #1 check("roll_before_edge", o_roll, 0);
    step();
    check("roll_after_edge", o_roll, 1);

    // Table of single requests with distinct consecutive offsets.
    for (int i = 0; i < 6; i++) begin
      request(vecs[i].raw);
      check($sformatf("v%0d_busy_after_capture", i), o_busy, 1);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_value", i), o_value, vecs[i].exp_val);
      check($sformatf("v%0d_busy_in_valid", i), o_busy, 0);
      do_ack();
      check($sformatf("v%0d_valid_dropped", i), o_valid, 0);
      check($sformatf("v%0d_value_retained", i), o_value, vecs[i].exp_val);
      check($sformatf("v%0d_roll", i), o_roll, 1);
    end

    // Maximum subtractions, then hold without ack.
    request(7'd127);
    wait_valid(lat);
    check("max_sub_latency", lat, 4);
    check("max_sub_value", o_value, 17);
    i_random_binary = 7'd99;
    i_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold%0d_valid", i), o_valid, 1);
      check($sformatf("hold%0d_value", i), o_value, 17);
    end
    i_req = 1'b0;
    do_ack();

    // Repeat of offset 7 is rejected; the resampled raw 8 is delivered as 18.
    request(7'd47);
    step();
    step();
    check("resample_state", dut.state_q, RESAMPLE);
    check("resample_busy", o_busy, 1);
    i_random_binary = 7'd8;
    wait_valid(lat);
    check("resample_latency", lat, 2);
    check("resample_value", o_value, 18);
    do_ack();

    // Re-establish offset 7, then hold raw at 47 so every retry is exhausted.
    request(7'd7);
    wait_valid(lat);
    check("seed7_value", o_value, 17);
    do_ack();
    request(7'd47);
    wait_valid(lat);
    check("exhaust_latency", lat, 11);
    check("exhaust_value", o_value, 17);
    check("exhaust_retry", dut.retry_q, 3);
    do_ack();

    // Req and ack together in VALID: ack wins, capture happens one edge later.
    request(7'd5);
    wait_valid(lat);
    check("overlap_pre_value", o_value, 15);
    i_random_binary = 7'd20;
    i_req = 1'b1;
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    check("overlap_valid_low", o_valid, 0);
    check("overlap_no_capture", o_busy, 0);
    step();
    i_req = 1'b0;
    check("overlap_capture_next", o_busy, 1);
    wait_valid(lat);
    check("overlap_latency", lat, 1);
    check("overlap_value", o_value, 30);
    do_ack();

    // Ack in IDLE has no effect.
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    check("idle_ack_busy", o_busy, 0);
    check("idle_ack_valid", o_valid, 0);
    check("idle_ack_value", o_value, 30);

    // Reset during REDUCE clears have_last, so offset 7 is then accepted.
    request(7'd7);
    wait_valid(lat);
    check("pre_reset_value", o_value, 17);
    do_ack();
    request(7'd127);
    step();
    check("mid_reduce_busy", o_busy, 1);
    #2 rst_sampler_n = 1'b0;
    #1;
    check("async_rst_roll",  o_roll,  0);
    check("async_rst_busy",  o_busy,  0);
    check("async_rst_valid", o_valid, 0);
    check("async_rst_value", o_value, 0);
    @(negedge clk_sampler);
    rst_sampler_n = 1'b1;
    #1 check("post_rst_roll_low", o_roll, 0);
    step();
    check("post_rst_roll_high", o_roll, 1);
    check("post_rst_idle", o_busy, 0);
    request(7'd47);
    wait_valid(lat);
    check("post_rst_latency", lat, 2);
    check("post_rst_value", o_value, 17);
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
